// File: rtl/regfile_hilo_commit.sv
// Commit-side register state: 32x32 GPR file, HI/LO pair, four combinational read ports,
// and a small FIFO that serializes committed GPR writes into a one-per-cycle debug trace.
module regfile_hilo_commit #(
    parameter int BYPASS      = 1,
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] write_reg_1,
    input  logic [37:0] write_reg_2,
    input  logic [31:0] write_pc_1,
    input  logic [31:0] write_pc_2,
    input  logic [64:0] write_hilo_1,
    input  logic [64:0] write_hilo_2,
    input  logic [4:0]  raddr [4],
    output logic [31:0] rdata [4],
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_value,
    output logic [3:0]  trace_wen,
    input  logic        trace_ready,
    output logic        trace_full
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;

    // Handshake: an entry is presented while trace_wen=F; it leaves the FIFO on any
    // edge where trace_ready=1. trace_full=1 tells the Write stage to hold.

    logic [4:0]  wd1, wd2;
    logic [31:0] wval1, wval2;
    logic        we1, we2;

    assign wd1   = write_reg_1[36:32];
    assign wd2   = write_reg_2[36:32];
    assign wval1 = write_reg_1[31:0];
    assign wval2 = write_reg_2[31:0];
    assign we1   = write_reg_1[37] && (wd1 != 5'd0);
    assign we2   = write_reg_2[37] && (wd2 != 5'd0);

    logic [31:0] gpr [32];
    logic [31:0] hi_q, lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            // Slot 2 is younger, so its write is applied last and wins on a shared dst.
            if (we1) gpr[wd1] <= wval1;
            if (we2) gpr[wd2] <= wval2;
            if (write_hilo_2[64]) begin
                hi_q <= write_hilo_2[63:32];
                lo_q <= write_hilo_2[31:0];
            end else if (write_hilo_1[64]) begin
                hi_q <= write_hilo_1[63:32];
                lo_q <= write_hilo_1[31:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = gpr[raddr[i]];
            if (BYPASS != 0) begin
                if (we2 && (wd2 == raddr[i]))      rdata[i] = wval2;
                else if (we1 && (wd1 == raddr[i])) rdata[i] = wval1;
            end
            if (raddr[i] == 5'd0) rdata[i] = 32'd0;
        end
    end

    always_comb begin
        hi = hi_q;
        lo = lo_q;
        if (BYPASS != 0) begin
            if (write_hilo_2[64]) begin
                hi = write_hilo_2[63:32];
                lo = write_hilo_2[31:0];
            end else if (write_hilo_1[64]) begin
                hi = write_hilo_1[63:32];
                lo = write_hilo_1[31:0];
            end
        end
    end

    logic [31:0]   f_pc  [TRACE_DEPTH];
    logic [4:0]    f_reg [TRACE_DEPTH];
    logic [31:0]   f_val [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          trace_ovf;
    logic          acc1, acc2, pop;
    logic [CW-1:0] n_enq;
    logic [PW-1:0] wr_ptr2;

    assign trace_full = (count > CW'(TRACE_DEPTH - 2));
    assign acc1       = we1 && !trace_full;
    assign acc2       = we2 && !trace_full;
    assign n_enq      = CW'(acc1) + CW'(acc2);
    assign pop        = trace_ready && (count != '0);
    // Slot 2 lands right behind slot 1, or at the tail if slot 1 did not enqueue.
    assign wr_ptr2    = wr_ptr + PW'(acc1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            trace_ovf <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(n_enq);
            rd_ptr    <= rd_ptr + PW'(pop);
            count     <= count + n_enq - CW'(pop);
            trace_ovf <= trace_ovf || (trace_full && (we1 || we2));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (acc1) begin
                f_pc[wr_ptr]  <= write_pc_1;
                f_reg[wr_ptr] <= wd1;
                f_val[wr_ptr] <= wval1;
            end
            if (acc2) begin
                f_pc[wr_ptr2]  <= write_pc_2;
                f_reg[wr_ptr2] <= wd2;
                f_val[wr_ptr2] <= wval2;
            end
        end
    end

    always_comb begin
        trace_pc    = 32'd0;
        trace_reg   = 5'd0;
        trace_value = 32'd0;
        trace_wen   = 4'h0;
        if (count != '0) begin
            trace_pc    = f_pc[rd_ptr];
            trace_reg   = f_reg[rd_ptr];
            trace_value = f_val[rd_ptr];
            trace_wen   = 4'hF;
        end
    end
endmodule

// File: tb/tb_regfile_hilo_commit.sv
// Directed bench for regfile_hilo_commit: one bypassing and one non-bypassing instance
// share all inputs so same-cycle and next-cycle visibility can be compared.
module tb_regfile_hilo_commit;
    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] write_reg_1, write_reg_2;
    logic [31:0] write_pc_1, write_pc_2;
    logic [64:0] write_hilo_1, write_hilo_2;
    logic [4:0]  raddr [4];
    logic        trace_ready;

    logic [31:0] rdata [4];
    logic [31:0] hi, lo, trace_pc, trace_value;
    logic [4:0]  trace_reg;
    logic [3:0]  trace_wen;
    logic        trace_full;

    logic [31:0] rdata_nb [4];
    logic [31:0] hi_nb, lo_nb, trace_pc_nb, trace_value_nb;
    logic [4:0]  trace_reg_nb;
    logic [3:0]  trace_wen_nb;
    logic        trace_full_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_hilo_commit #(.BYPASS(1), .TRACE_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .write_reg_1(write_reg_1), .write_reg_2(write_reg_2),
        .write_pc_1(write_pc_1), .write_pc_2(write_pc_2),
        .write_hilo_1(write_hilo_1), .write_hilo_2(write_hilo_2),
        .raddr(raddr), .rdata(rdata), .hi(hi), .lo(lo),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_value(trace_value),
        .trace_wen(trace_wen), .trace_ready(trace_ready), .trace_full(trace_full)
    );

    regfile_hilo_commit #(.BYPASS(0), .TRACE_DEPTH(4)) dut_nb (
        .clk(clk), .reset(reset),
        .write_reg_1(write_reg_1), .write_reg_2(write_reg_2),
        .write_pc_1(write_pc_1), .write_pc_2(write_pc_2),
        .write_hilo_1(write_hilo_1), .write_hilo_2(write_hilo_2),
        .raddr(raddr), .rdata(rdata_nb), .hi(hi_nb), .lo(lo_nb),
        .trace_pc(trace_pc_nb), .trace_reg(trace_reg_nb), .trace_value(trace_value_nb),
        .trace_wen(trace_wen_nb), .trace_ready(trace_ready), .trace_full(trace_full_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_writes();
        write_reg_1  = '0;
        write_reg_2  = '0;
        write_pc_1   = '0;
        write_pc_2   = '0;
        write_hilo_1 = '0;
        write_hilo_2 = '0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] val);
        check({tag, "_wen"}, 32'(trace_wen), 32'hF);
        check({tag, "_pc"}, trace_pc, pc);
        check({tag, "_reg"}, 32'(trace_reg), 32'(rd));
        check({tag, "_val"}, trace_value, val);
    endtask

    initial begin
        reset       = 1'b1;
        trace_ready = 1'b0;
        clear_writes();
        for (int i = 0; i < 4; i++) raddr[i] = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd3; raddr[3] = 5'd0;
        settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            check($sformatf("rst_rdata_nb%0d", i), rdata_nb[i], 32'd0);
        end
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_wen", 32'(trace_wen), 32'd0);
        check("rst_full", 32'(trace_full), 32'd0);
        check("rst_trace_pc", trace_pc, 32'd0);

        // Same dst on both slots: slot 2 wins, both traced in slot order
        write_reg_1 = {1'b1, 5'd5, 32'h11111111}; write_pc_1 = 32'h100;
        write_reg_2 = {1'b1, 5'd5, 32'h22222222}; write_pc_2 = 32'h104;
        raddr[0] = 5'd5;
        settle();
        check("byp_prio", rdata[0], 32'h22222222);
        check("nobyp_same", rdata_nb[0], 32'd0);
        tick();
        clear_writes();
        settle();
        check("dual_store", rdata[0], 32'h22222222);
        check("dual_store_nb", rdata_nb[0], 32'h22222222);
        check("dual_full", 32'(trace_full), 32'd0);
        expect_head("tr1", 32'h100, 5'd5, 32'h11111111);
        trace_ready = 1'b1;
        tick();
        settle();
        expect_head("tr2", 32'h104, 5'd5, 32'h22222222);
        tick();
        settle();
        check("tr_empty", 32'(trace_wen), 32'd0);
        trace_ready = 1'b0;

        // Same-cycle bypass vs next-cycle visibility
        write_reg_1 = {1'b1, 5'd7, 32'hDEADBEEF}; write_pc_1 = 32'h200;
        raddr[0] = 5'd7; raddr[3] = 5'd7;
        settle();
        check("byp_r7", rdata[0], 32'hDEADBEEF);
        check("byp_r7_port3", rdata[3], 32'hDEADBEEF);
        check("nobyp_r7", rdata_nb[0], 32'd0);
        tick();
        clear_writes();
        settle();
        check("nobyp_r7_next", rdata_nb[0], 32'hDEADBEEF);
        check("byp_r7_next", rdata[0], 32'hDEADBEEF);
        check("r7_trace_reg", 32'(trace_reg), 32'd7);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        raddr[3] = 5'd0;

        // Writes to r0 are discarded
        write_reg_1 = {1'b1, 5'd0, 32'hFFFFFFFF};
        write_reg_2 = {1'b1, 5'd0, 32'hFFFFFFFF};
        raddr[0] = 5'd0;
        settle();
        check("r0_byp", rdata[0], 32'd0);
        tick();
        clear_writes();
        settle();
        check("r0_store", rdata[0], 32'd0);
        check("r0_no_trace", 32'(trace_wen), 32'd0);
        check("r0_count", 32'(dut.count), 32'd0);

        // Fill the FIFO with trace_ready held low; full only once count exceeds DEPTH-2
        write_reg_1 = {1'b1, 5'd8, 32'hA1}; write_pc_1 = 32'h300;
        write_reg_2 = {1'b1, 5'd9, 32'hA2}; write_pc_2 = 32'h304;
        tick();
        settle();
        check("fill1_full", 32'(trace_full), 32'd0);
        write_reg_1 = {1'b1, 5'd10, 32'hA3}; write_pc_1 = 32'h308;
        write_reg_2 = {1'b1, 5'd11, 32'hA4}; write_pc_2 = 32'h30C;
        tick();
        settle();
        check("fill2_full", 32'(trace_full), 32'd1);
        check("fill2_ovf", 32'(dut.trace_ovf), 32'd0);
        write_reg_1 = {1'b1, 5'd12, 32'hA5}; write_pc_1 = 32'h310;
        write_reg_2 = {1'b1, 5'd13, 32'hA6}; write_pc_2 = 32'h314;
        tick();
        clear_writes();
        raddr[1] = 5'd12; raddr[2] = 5'd13;
        settle();
        check("ovf_gpr12", rdata[1], 32'hA5);
        check("ovf_gpr13", rdata[2], 32'hA6);
        check("ovf_flag", 32'(dut.trace_ovf), 32'd1);
        check("ovf_count", 32'(dut.count), 32'd4);
        expect_head("ovf_h0", 32'h300, 5'd8, 32'hA1);
        trace_ready = 1'b1;
        tick(); settle();
        expect_head("ovf_h1", 32'h304, 5'd9, 32'hA2);
        check("drain_full", 32'(trace_full), 32'd1);
        tick(); settle();
        expect_head("ovf_h2", 32'h308, 5'd10, 32'hA3);
        check("drain_not_full", 32'(trace_full), 32'd0);
        tick(); settle();
        expect_head("ovf_h3", 32'h30C, 5'd11, 32'hA4);
        tick(); settle();
        check("drain_empty", 32'(trace_wen), 32'd0);
        trace_ready = 1'b0;

        // HI/LO: slot 2 wins, then slot 1 alone
        write_hilo_1 = {1'b1, 32'hA, 32'hB};
        write_hilo_2 = {1'b1, 32'hC, 32'hD};
        settle();
        check("hilo_byp_hi", hi, 32'hC);
        check("hilo_byp_lo", lo, 32'hD);
        check("hilo_nb_hi", hi_nb, 32'd0);
        tick();
        clear_writes();
        settle();
        check("hilo_hi", hi, 32'hC);
        check("hilo_lo", lo, 32'hD);
        check("hilo_nb_lo", lo_nb, 32'hD);
        write_hilo_1 = {1'b1, 32'h12345678, 32'h9ABCDEF0};
        tick();
        clear_writes();
        settle();
        check("hilo1_hi", hi_nb, 32'h12345678);
        check("hilo1_lo", lo_nb, 32'h9ABCDEF0);

        // Mid-operation reset with a pending trace entry and writes in the reset cycle
        write_reg_1 = {1'b1, 5'd3, 32'h55};
        tick();
        reset = 1'b1;
        write_reg_1 = {1'b1, 5'd4, 32'h66};
        write_hilo_1 = {1'b1, 32'h77, 32'h88};
        tick();
        reset = 1'b0;
        clear_writes();
        raddr[0] = 5'd5; raddr[1] = 5'd3; raddr[2] = 5'd4; raddr[3] = 5'd12;
        settle();
        for (int i = 0; i < 4; i++) check($sformatf("mid_rst_rdata%0d", i), rdata[i], 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_wen", 32'(trace_wen), 32'd0);
        check("mid_rst_count", 32'(dut.count), 32'd0);
        check("mid_rst_ovf", 32'(dut.trace_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
